freq_div_ctrl: RTL and testbench
================================

# freq_div_ctrl

Run-control and configuration sequencer for the team's integer clock-divider counter. Accepts divide-ratio and high-time settings over a valid/ready handshake and starts and stops the divider on a level request. It applies new settings only on period boundaries, so the divided output never carries a truncated or glitched period. It sits between the register/control interface and the divider datapath, and emits the divided waveform plus a period-start tick.

## Interface
Parameters:
- `CNT_W`, default 8: width of counter, divide ratio and high-time fields.
- `RST_DIV`, default 3: active divide ratio after reset.
- `RST_HIGH`, default 1: active high time after reset. Reset output is divide-by-3 at 33.3 % duty.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: level run request.
- `cfg_valid`, in, 1: configuration offered.
- `cfg_ready`, out, 1: configuration can be accepted.
- `cfg_div`, in, `CNT_W`: divide ratio N.
- `cfg_high`, in, `CNT_W`: high cycles H per period.
- `cfg_err`, out, 1: one-cycle pulse when a configuration is rejected.
- `busy`, out, 1: state is not IDLE.
- `div_out`, out, 1: registered divided waveform.
- `tick`, out, 1: registered one-cycle pulse in the first cycle of every period.
- `count`, out, `CNT_W`: registered position within the current period, 0..N-1.

## Operation
- **Reset values:**
  - state IDLE; `count`=0.
  - `div_out`=0, `tick`=0, `busy`=0, `cfg_err`=0, `cfg_ready`=1.
  - active N/H = `RST_DIV`/`RST_HIGH`; no pending configuration.
- **States:** IDLE, RUN, DRAIN.
  - IDLE -> RUN when `start`=1.
  - RUN -> DRAIN when `start`=0.
  - DRAIN -> RUN when `start`=1. No discontinuity; `count` keeps running.
  - DRAIN -> IDLE at the end of the current period, i.e. the edge where `count`=N-1.
- **Counting:**
  - In RUN and DRAIN, `count` increments and wraps N-1 -> 0.
  - `div_out`=1 iff `count` < H.
  - `tick`=1 iff `count`=0.
  - In IDLE: `count`=0, `div_out`=0, `tick`=0.
- **Configuration validity:**
  - A handshake occurs on an edge where `cfg_valid` and `cfg_ready` are both 1.
  - A configuration is valid iff 2 <= N and 1 <= H <= N-1.
  - Invalid configuration: discarded, `cfg_err` pulses the next cycle, `cfg_ready` stays 1, active and pending settings unchanged.
- **Applying configuration:**
  - In IDLE: a valid configuration is written directly to the active registers.
  - In RUN or DRAIN: a valid configuration goes to the pending register and `cfg_ready` drops to 0.
  - At the next wrap edge (`count`=N-1), pending is copied to active and `cfg_ready` returns to 1. The new period uses the new N/H from its first cycle.
  - A DRAIN -> IDLE transition also applies pending.
- **Boundary cases:**
  - Handshake on the same edge as a wrap: the configuration is stored as pending and applied at the following wrap.
  - `start` falling and `cfg` accepted together: normal DRAIN; pending is applied at DRAIN exit.
  - `rst` mid-period: all state returns to reset values immediately. Pending is lost and active reverts to `RST_DIV`/`RST_HIGH`.
- **Width rules:** comparisons are unsigned at `CNT_W`; no arithmetic wider than `CNT_W`.

## Timing
- Start latency: `start` sampled 1 at edge t in IDLE gives `count`=0, `tick`=1, `div_out`=1 and `busy`=1 in cycle t+1.
- Period is exactly N cycles with `div_out` high for exactly H of them.
- Stop: `div_out` stays 0 and `busy` falls in the cycle after the `count`=N-1 cycle of the period during which `start` was seen low.
- `cfg_err` is asserted exactly 1 cycle after the rejecting handshake.
- `cfg_ready` falls in the cycle after a RUN/DRAIN acceptance.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `freq_div_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the default `CNT_W`, `RST_DIV` and `RST_HIGH` constants;
  - a packed config struct {div, high}.
- One sub-module, `div_counter`: holds the period counter and the `div_out`/`tick` generation. Inputs: enable, active N/H. Output: wrap flag.
- The FSM, config validation, and the shadow/pending registers stay in `freq_div_ctrl`.

## Test plan
- **Reset default.** Stimulus: reset, then `start`=1 held for 12 cycles. Required: `tick` at cycles 1, 4, 7, 10; `div_out` pattern 100 repeated; `count` sequence 0,1,2.
- **Live reconfiguration.** Stimulus: N=5/H=2 issued at `count`=1 while running at N=3. Required: `cfg_ready` is 0 until the wrap; the next period is 11000; no 3-cycle or partial period appears.
- **Invalid configurations.** Stimulus: N=1/H=0, then N=4/H=4. Required: `cfg_err` pulses each once one cycle later; the active divide-by-3 output is unchanged.
- **Stop and restart.** Stimulus: `start` dropped at `count`=0 with N=4/H=1. Required: 3 more cycles of the period, then IDLE with `busy`=0. Re-raising `start` during DRAIN keeps RUN with no gap.
- **Reset mid-period.** Stimulus: `rst` pulse mid-period with a configuration pending. Required: outputs 0 asynchronously; restart yields divide-by-3 at H=1.
- **Wrap coincidence.** Stimulus: handshake on the wrap edge. Required: new N/H takes effect one full period later.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared types and reset defaults for the run-control sequencer of the integer clock divider.
package freq_div_pkg;

    localparam int unsigned CntW    = 8;
    localparam int unsigned RstDiv  = 3;
    localparam int unsigned RstHigh = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Divide ratio N and high time H, sized at the package counter width.
    typedef struct packed {
        logic [CntW-1:0] div;
        logic [CntW-1:0] high;
    } div_cfg_t;

endpackage

// File: rtl/div_counter.sv
// Period counter with registered divided waveform and period-start tick.
module div_counter
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W = CntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             en_nxt,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] high_nxt,
    output logic [CNT_W-1:0] count,
    output logic             div_out,
    output logic             tick,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             div_out_q, tick_q;

    assign wrap = en && (count_q == div - CNT_W'(1));

    always_comb begin
        count_d = '0;
        if (en && !wrap) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Waveform is derived from the next count and next high time so it is registered
    // yet already reflects a configuration applied on the wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            div_out_q <= en_nxt && (count_d < high_nxt);
            tick_q    <= en_nxt && (count_d == '0);
        end
    end

    assign count   = count_q;
    assign div_out = div_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Run-control FSM and configuration sequencer; new settings only take effect on period boundaries.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CntW,
    parameter int unsigned RST_DIV  = RstDiv,
    parameter int unsigned RST_HIGH = RstHigh
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             busy,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    state_e   state_q, state_d;
    div_cfg_t act_q, act_d, pend_q, pend_d;
    logic     pend_vld_q, pend_vld_d;
    logic     err_q;
    logic     hs, cfg_ok, wrap, running;

    assign running = (state_q != StIdle);
    assign hs      = cfg_valid && cfg_ready;
    assign cfg_ok  = (cfg_div >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (!start) state_d = StDrain;
            StDrain: begin
                if (start) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (wrap && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        // Anything accepted while idle, or on the edge that returns to idle, has no
        // period to wait for and goes straight to the active settings.
        if (hs && cfg_ok) begin
            if (state_q == StIdle || state_d == StIdle) begin
                act_d = '{div: cfg_div, high: cfg_high};
            end else begin
                pend_d     = '{div: cfg_div, high: cfg_high};
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            act_q      <= '{div: CntW'(RST_DIV), high: CntW'(RST_HIGH)};
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= hs && !cfg_ok;
        end
    end

    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = err_q;
    assign busy      = running;

    div_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .en_nxt  (state_d != StIdle),
        .div     (act_q.div),
        .high_nxt(act_d.high),
        .count   (count),
        .div_out (div_out),
        .tick    (tick),
        .wrap    (wrap)
    );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed scenarios plus a randomized run against a period model.
module tb_freq_div_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic         cfg_ready, cfg_err, busy, div_out, tick;
    logic [W-1:0] count;

    int total = 0;
    int bad = 0;

    wire [W+4:0] obs = {busy, tick, div_out, cfg_ready, cfg_err, count};

    always #5 clk = ~clk;

    freq_div_ctrl #(
        .CNT_W   (W),
        .RST_DIV (3),
        .RST_HIGH(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_err  (cfg_err),
        .busy     (busy),
        .div_out  (div_out),
        .tick     (tick),
        .count    (count)
    );

    function automatic logic [W+4:0] pack(input logic b, input logic t, input logic d,
                                          input logic r, input logic e, input int c);
        return {b, t, d, r, e, W'(c)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start     = 1'b0;
        cfg_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_count(input int c, input string name);
        int n = 0;
        while (count !== W'(c) && n < 32) begin
            step();
            n++;
        end
        if (n == 32) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for count=%0d, count=%0d", name, c, count);
        end
    endtask

    task automatic test_reset();
        logic [W+4:0] exp;
        int c;
        rst = 1'b1;
        #3;
        total++;
        if (obs !== pack(0, 0, 0, 1, 0, 0)) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", obs, pack(0, 0, 0, 1, 0, 0));
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            c   = (i - 1) % 3;
            exp = pack(1, c == 0, c < 1, 1, 0, c);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_default cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_live_reconfig();
        logic [W+4:0] exp;
        int c;
        wait_count(1, "live_reconfig");
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        cfg_high  = 8'd2;
        step();
        cfg_valid = 1'b0;
        exp = pack(1, 0, 0, 0, 0, 2);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL live_pending got=%h want=%h", obs, exp);
        end
        for (int j = 0; j < 6; j++) begin
            step();
            c   = j % 5;
            exp = pack(1, c == 0, c < 2, 1, 0, c);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL live_new_period j=%0d got=%h want=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_invalid();
        logic [W+4:0] exp;
        int c;
        do_reset();
        start = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            cfg_valid = (i == 0 || i == 2);
            cfg_div   = (i == 0) ? 8'd1 : 8'd4;
            cfg_high  = (i == 0) ? 8'd0 : 8'd4;
            step();
            c   = (i + 1) % 3;
            exp = pack(1, c == 0, c < 1, 1, (i == 0 || i == 2), c);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL invalid_cfg i=%0d got=%h want=%h", i, obs, exp);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_stop_restart();
        logic [W+4:0] exp;
        logic         st[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int           cn[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        cfg_high  = 8'd1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            step();
            exp = pack(1, (i % 4) == 0, (i % 4) < 1, 1, 0, i % 4);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL stop_run i=%0d got=%h want=%h", i, obs, exp);
            end
        end
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp = (i <= 3) ? pack(1, 0, 0, 1, 0, i) : pack(0, 0, 0, 1, 0, 0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL stop_drain i=%0d got=%h want=%h", i, obs, exp);
            end
        end
        for (int i = 0; i < 6; i++) begin
            start = st[i];
            step();
            exp = pack(1, cn[i] == 0, cn[i] < 1, 1, 0, cn[i]);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL restart_no_gap i=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W+4:0] exp;
        int c;
        do_reset();
        start = 1'b1;
        step();
        step();
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        cfg_high  = 8'd3;
        step();
        cfg_valid = 1'b0;
        exp = pack(1, 0, 0, 0, 0, 2);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL rst_mid_pending got=%h want=%h", obs, exp);
        end
        #2;
        rst = 1'b1;
        #1;
        exp = pack(0, 0, 0, 1, 0, 0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL rst_mid_async got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            c   = i % 3;
            exp = pack(1, c == 0, c < 1, 1, 0, c);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rst_mid_restart i=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_wrap_coincide();
        logic [W+4:0] exp;
        int c;
        do_reset();
        start = 1'b1;
        step();
        step();
        step();
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        cfg_high  = 8'd2;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                exp = pack(1, i == 0, i < 1, 0, 0, i);
            end else begin
                c   = (i - 3) % 4;
                exp = pack(1, c == 0, c < 2, 1, 0, c);
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL wrap_coincide i=%0d got=%h want=%h", i, obs, exp);
            end
            step();
        end
    endtask

    // Model: a period of n cycles is running or not; a stop request ends it at its last
    // cycle; a queued config replaces n/h when the next period begins.
    task automatic test_random();
        int on = 0, stopping = 0, pos = 0, n = 3, h = 1;
        int pn[$], ph[$];
        logic s, v, rdy, hs, ok, err, fin, last;
        int dv, hv;
        logic [W+4:0] exp;
        do_reset();
        start = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(15) == 0) start = ~start;
            cfg_valid = ($urandom_range(5) == 0);
            cfg_div   = W'($urandom_range(7));
            cfg_high  = W'($urandom_range(7));
            s   = start;
            v   = cfg_valid;
            dv  = int'(cfg_div);
            hv  = int'(cfg_high);
            rdy = (pn.size() == 0);
            step();
            hs  = v && rdy;
            ok  = (dv >= 2) && (hv >= 1) && (hv < dv);
            err = hs && !ok;
            if (on == 0) begin
                if (hs && ok) begin
                    n = dv;
                    h = hv;
                end
                if (s) begin
                    on  = 1;
                    pos = 0;
                end
            end else begin
                last = (pos == n - 1);
                fin  = last && (stopping != 0) && !s;
                if (last) begin
                    pos = 0;
                    if (pn.size() > 0) begin
                        n = pn.pop_front();
                        h = ph.pop_front();
                    end
                end else begin
                    pos++;
                end
                if (hs && ok) begin
                    if (fin) begin
                        n = dv;
                        h = hv;
                    end else begin
                        pn.push_back(dv);
                        ph.push_back(hv);
                    end
                end
                if (fin) on = 0;
            end
            stopping = s ? 0 : 1;
            exp = pack(on != 0, (on != 0) && pos == 0, (on != 0) && pos < h, pn.size() == 0,
                       err, (on != 0) ? pos : 0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_live_reconfig();
        test_invalid();
        test_stop_restart();
        test_reset_mid();
        test_wrap_coincide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
